control_loop_cmd_queue: RTL

Host-side command front end placed directly upstream of control_loop's command port (cmd, word_into_loop, start_cmd, finish_cmd, word_outof_loop).
- Buffers host {cmd, word} requests in a small synchronous FIFO.
- Issues them to control_loop one at a time using the 4-phase start/finish handshake.
- Returns each loop reply through a valid/ready response register.
- Decouples the host bus from loop command latency.

---
 rtl/control_loop_cmd_queue_pkg.sv | 15 +
 rtl/control_loop_cmd_queue_fifo.sv | 45 ++++
 rtl/control_loop_cmd_queue.sv | 110 +++++++++++
 3 files changed

// File: rtl/control_loop_cmd_queue_pkg.sv
// control_loop_cmds: opcode width, opcode values and FSM encodings shared by
// the command queue and its users.
package control_loop_cmds;
    localparam int CONTROL_LOOP_CMD_WIDTH = 4;

    localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CL_CMD_NOP       = 4'd0;
    localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CL_CMD_READ_REG  = 4'd1;
    localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CL_CMD_WRITE_REG = 4'd2;
    localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CL_CMD_RUN_STEP  = 4'd3;
    localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CL_CMD_RESET_INT = 4'd4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_FIN = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;
endpackage

// File: rtl/control_loop_cmd_queue_fifo.sv
// cmd_fifo: synchronous FIFO of 2^DEPTH_LEN entries with occupancy output;
// pushes when full and pops when empty are ignored.
module cmd_fifo #(
    parameter int WID       = 52,
    parameter int DEPTH_LEN = 2
) (
    input  logic                 clk,
    input  logic                 rst_L,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WID-1:0]       din,
    output logic [WID-1:0]       dout,
    output logic [DEPTH_LEN:0]   level,
    output logic                 full,
    output logic                 empty
);
    localparam int LW    = DEPTH_LEN + 1;
    localparam int DEPTH = 1 << DEPTH_LEN;

    logic [WID-1:0]       mem [DEPTH];
    logic [DEPTH_LEN-1:0] wr_ptr, rd_ptr;
    logic                 do_push, do_pop;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/control_loop_cmd_queue.sv
// control_loop_cmd_queue: buffers host commands and issues them to control_loop
// over the start/finish handshake. Optional abort: CONTROL_LOOP_CMD_TIMEOUT_EN.
module control_loop_cmd_queue
    import control_loop_cmds::*;
#(
    parameter int CONSTS_WID     = 48,
    parameter int CMD_WID        = CONTROL_LOOP_CMD_WIDTH,
    parameter int FIFO_DEPTH_LEN = 2,
    parameter int TIMEOUT_WID    = 16
) (
    input  logic                    clk,
    input  logic                    rst_L,
    input  logic [CMD_WID-1:0]      host_cmd,
    input  logic [CONSTS_WID-1:0]   host_word,
    input  logic                    host_valid,
    output logic                    host_ready,
    output logic [CMD_WID-1:0]      resp_cmd,
    output logic [CONSTS_WID-1:0]   resp_word,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_timeout,
    output logic [FIFO_DEPTH_LEN:0] fifo_level,
    output logic                    busy,
    output logic [CMD_WID-1:0]      loop_cmd,
    output logic [CONSTS_WID-1:0]   loop_word,
    output logic                    loop_start,
    input  logic                    loop_finish,
    input  logic [CONSTS_WID-1:0]   loop_word_out
);
    logic [1:0]                    state;
    logic [CMD_WID+CONSTS_WID-1:0] head;
    logic                          fifo_full, fifo_empty, pop, tmo_hit;

    // A stale finish from the previous command must drop before the next issue.
    assign pop        = state == ST_IDLE && !fifo_empty && !resp_valid && !loop_finish;
    assign host_ready = !fifo_full;
    assign busy       = state != ST_IDLE || !fifo_empty;

    cmd_fifo #(
        .WID       (CMD_WID + CONSTS_WID),
        .DEPTH_LEN (FIFO_DEPTH_LEN)
    ) u_fifo (
        .clk   (clk),
        .rst_L (rst_L),
        .push  (host_valid),
        .pop   (pop),
        .din   ({host_cmd, host_word}),
        .dout  (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
    logic [TIMEOUT_WID-1:0] tmo_cnt;
    assign tmo_hit = &tmo_cnt;
`else
    assign tmo_hit      = TIMEOUT_WID < 0;
    assign resp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state      <= ST_IDLE;
            loop_cmd   <= '0;
            loop_word  <= '0;
            loop_start <= 1'b0;
            resp_cmd   <= '0;
            resp_word  <= '0;
            resp_valid <= 1'b0;
`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
            tmo_cnt      <= '0;
            resp_timeout <= 1'b0;
`endif
        end else begin
            if (resp_valid && resp_ready) resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {loop_cmd, loop_word} <= head;
                        state <= ST_WAIT_FIN;
`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                ST_WAIT_FIN: begin
`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (loop_finish || tmo_hit) resp_timeout <= !loop_finish;
`endif
                    // Strobe rises one cycle after the operands are loaded.
                    if (loop_finish || tmo_hit) begin
                        loop_start <= 1'b0;
                        resp_cmd   <= loop_cmd;
                        resp_word  <= loop_finish ? loop_word_out : '0;
                        resp_valid <= 1'b1;
                        state      <= ST_WAIT_REL;
                    end else begin
                        loop_start <= 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    if (!loop_finish) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
